oled_power_sequencer: RTL and testbench
=======================================

// Module: oled_power_sequencer
// PURPOSE
//  Sequences SSD1306 OLED power rails and reset on the Nexys Video FPGA target; sits beside the SoC top.
//  Drives the VDD, VBAT and RES pins (active-low) with datasheet-safe timing.
//  Hands the SPI command phases (init / display-off) to an external SPI master via a req/done handshake.
//  Power is controlled by the level input enable_i.
// PARAMETERS
//  T_VDD_CYC   50000    VDD-on to RES-assert settle time, in cycles (1 ms @ 50 MHz)
//  T_RST_CYC   250      RES low pulse width, in cycles (5 us)
//  T_VBAT_CYC  5000000  VBAT settle time after on or off, in cycles (100 ms)
//  CNT_W       23       timer width; must hold max(T_*_CYC)-1
// PORTS
//  clk_i       in   1      clock
//  rst_i       in   1      synchronous reset, active-high
//  enable_i    in   1      1 = display powered, 0 = display off (level)
//  cmd_done_i  in   1      1-cycle pulse from SPI master: command phase finished
//  cmd_req_o   out  1      command phase requested; held until cmd_done_i
//  cmd_sel_o   out  1      0 = init sequence, 1 = display-off command
//  vdd_n_o     out  1      logic VDD enable, active-low
//  vbat_n_o    out  1      panel VBAT enable, active-low
//  res_n_o     out  1      display reset, active-low
//  ready_o     out  1      1 only in ON
//  busy_o      out  1      1 in every state except OFF and ON
//  state_o     out  4      current FSM state encoding, for debug
// BEHAVIOUR
//  Reset values: state OFF, vdd_n_o=1, vbat_n_o=1, res_n_o=0, cmd_req_o=0, cmd_sel_o=0, ready_o=0, busy_o=0, timer=0.
//  All outputs are registered and are a function of state only.
//  Timer: loads T-1 on state entry and decrements; the state exits in the cycle the timer reads 0, so a timed state lasts exactly T cycles.
//  States, encodings and transitions:
//   OFF(0)       : vdd=off, vbat=off, res=0. Goes to VDD_WAIT when enable_i=1.
//   VDD_WAIT(1)  : vdd on, res=0. Goes to RST_HI after T_VDD_CYC.
//   RST_HI(2)    : res=1 for T_RST_CYC, then to RST_LO (release glitch guard).
//   RST_LO(3)    : res=0 for T_RST_CYC, then to RST_REL.
//   RST_REL(4)   : res=1 for T_RST_CYC, then to CMD_INIT.
//   CMD_INIT(5)  : cmd_req_o=1, cmd_sel_o=0. Goes to VBAT_ON on cmd_done_i.
//   VBAT_ON(6)   : vbat on; goes to ON after T_VBAT_CYC.
//   ON(7)        : ready_o=1. Goes to CMD_OFF when enable_i=0.
//   CMD_OFF(8)   : cmd_req_o=1, cmd_sel_o=1. Goes to VBAT_OFF on cmd_done_i.
//   VBAT_OFF(9)  : vbat off; goes to OFF after T_VBAT_CYC (vdd stays on until OFF).
//  Handshake:
//   - cmd_req_o rises the cycle after entry and falls in the cycle after cmd_done_i is sampled.
//   - cmd_done_i is ignored while cmd_req_o=0.
//   - cmd_done_i in the same cycle cmd_req_o rises is accepted.
//  enable_i drop mid-sequence:
//   - VDD_WAIT or RST_* (VBAT never on): go directly to OFF next cycle.
//   - CMD_INIT: complete the handshake, then go to CMD_OFF instead of VBAT_ON.
//   - VBAT_ON: go to CMD_OFF next cycle.
//  enable_i re-asserted during CMD_OFF or VBAT_OFF: the power-down completes to OFF; restart from OFF.
//  rst_i mid-operation: immediately returns to reset values (rails drop; acceptable on FPGA reset).
//  Invariants: vbat_n_o=0 implies vdd_n_o=0; VBAT is never on in OFF or VDD_WAIT.
// CONFIGURATION
//  OLED_SEQ_AUTOSTART_EN defined:
//   - Powers up once after reset as if enable_i=1, until enable_i is first seen high and then low.
//   - After that enable_i has full control.
//  OLED_SEQ_AUTOSTART_EN undefined: sequencing starts only on enable_i=1.
// TESTING (use T_VDD_CYC=10, T_RST_CYC=3, T_VBAT_CYC=20; SPI model answers cmd_done_i 5 cycles after req)
//  - enable_i=1 at cycle 0 after reset -> vdd_n_o falls at cycle 1; res_n_o goes 1/0/1 for 3 cycles each starting cycle 11; cmd_req_o=1 with cmd_sel_o=0; vbat_n_o=0 after done; ready_o=1 exactly 20 cycles later.
//  - From ON, drop enable_i -> cmd_req_o=1 with cmd_sel_o=1; after done, vbat_n_o=1; vdd_n_o=1 20 cycles later; busy_o=0 in OFF.
//  - Drop enable_i 4 cycles into VDD_WAIT -> OFF next cycle; vbat_n_o never 0; cmd_req_o never 1.
//  - Drop enable_i during CMD_INIT, then done -> state goes to CMD_OFF (8), not VBAT_ON; vbat_n_o stays 1.
//  - Pulse rst_i in VBAT_ON -> next cycle all outputs at reset values, state_o=0.
//  - OLED_SEQ_AUTOSTART_EN defined, enable_i=0 -> reaches ON; enable_i 1->0 -> full power-down to OFF.

Source files
------------

// File: rtl/oled_power_sequencer.sv
// SSD1306 OLED power-rail / reset sequencer with SPI command-phase handshake.
// Optional build macro OLED_SEQ_AUTOSTART_EN: power up once after reset without waiting for enable_i.
module oled_power_sequencer #(
  parameter int unsigned T_VDD_CYC  = 50000,
  parameter int unsigned T_RST_CYC  = 250,
  parameter int unsigned T_VBAT_CYC = 5000000,
  parameter int unsigned CNT_W      = 23
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       cmd_done_i,
  output logic       cmd_req_o,
  output logic       cmd_sel_o,
  output logic       vdd_n_o,
  output logic       vbat_n_o,
  output logic       res_n_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    ST_OFF      = 4'd0,
    ST_VDD_WAIT = 4'd1,
    ST_RST_HI   = 4'd2,
    ST_RST_LO   = 4'd3,
    ST_RST_REL  = 4'd4,
    ST_CMD_INIT = 4'd5,
    ST_VBAT_ON  = 4'd6,
    ST_ON       = 4'd7,
    ST_CMD_OFF  = 4'd8,
    ST_VBAT_OFF = 4'd9
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             abort_q, abort_d;
  logic             tmr_done;
  logic             en_eff;
  logic             vdd_n_d, vbat_n_d, res_n_d, req_d, sel_d, ready_d, busy_d;

`ifdef OLED_SEQ_AUTOSTART_EN
  // Until enable_i has been seen high once, behave as if it were held high.
  logic seen_hi_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seen_hi_q <= 1'b0;
    end else if (enable_i) begin
      seen_hi_q <= 1'b1;
    end
  end

  assign en_eff = enable_i | ~seen_hi_q;
`else
  assign en_eff = enable_i;
`endif

  assign tmr_done = (timer_q == '0);
  assign state_o  = state_q;

  // Next state, timer reload and next registered output values.
  always_comb begin
    state_d  = state_q;
    abort_d  = abort_q;
    timer_d  = tmr_done ? '0 : timer_q - CNT_W'(1);
    vdd_n_d  = 1'b1;
    vbat_n_d = 1'b1;
    res_n_d  = 1'b0;
    req_d    = 1'b0;
    sel_d    = 1'b0;
    ready_d  = 1'b0;
    busy_d   = 1'b1;

    case (state_q)
      ST_OFF: begin
        if (en_eff) state_d = ST_VDD_WAIT;
      end
      ST_VDD_WAIT: begin
        if (!en_eff)       state_d = ST_OFF;
        else if (tmr_done) state_d = ST_RST_HI;
      end
      ST_RST_HI: begin
        if (!en_eff)       state_d = ST_OFF;
        else if (tmr_done) state_d = ST_RST_LO;
      end
      ST_RST_LO: begin
        if (!en_eff)       state_d = ST_OFF;
        else if (tmr_done) state_d = ST_RST_REL;
      end
      ST_RST_REL: begin
        if (!en_eff)       state_d = ST_OFF;
        else if (tmr_done) state_d = ST_CMD_INIT;
      end
      ST_CMD_INIT: begin
        // A drop during the init phase is remembered so the handshake can finish first.
        if (!en_eff) abort_d = 1'b1;
        if (cmd_done_i && cmd_req_o) begin
          state_d = (abort_q || !en_eff) ? ST_CMD_OFF : ST_VBAT_ON;
        end
      end
      ST_VBAT_ON: begin
        if (!en_eff)       state_d = ST_CMD_OFF;
        else if (tmr_done) state_d = ST_ON;
      end
      ST_ON: begin
        if (!en_eff) state_d = ST_CMD_OFF;
      end
      ST_CMD_OFF: begin
        if (cmd_done_i && cmd_req_o) state_d = ST_VBAT_OFF;
      end
      ST_VBAT_OFF: begin
        if (tmr_done) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase

    if (state_d != state_q) begin
      abort_d = 1'b0;
      case (state_d)
        ST_VDD_WAIT:                      timer_d = CNT_W'(T_VDD_CYC - 1);
        ST_RST_HI, ST_RST_LO, ST_RST_REL: timer_d = CNT_W'(T_RST_CYC - 1);
        ST_VBAT_ON, ST_VBAT_OFF:          timer_d = CNT_W'(T_VBAT_CYC - 1);
        default:                          timer_d = '0;
      endcase
    end

    case (state_d)
      ST_OFF: busy_d = 1'b0;
      ST_VDD_WAIT: vdd_n_d = 1'b0;
      ST_RST_HI: begin
        vdd_n_d = 1'b0;
        res_n_d = 1'b1;
      end
      ST_RST_LO: vdd_n_d = 1'b0;
      ST_RST_REL: begin
        vdd_n_d = 1'b0;
        res_n_d = 1'b1;
      end
      ST_CMD_INIT: begin
        vdd_n_d = 1'b0;
        res_n_d = 1'b1;
        req_d   = 1'b1;
      end
      ST_VBAT_ON: begin
        vdd_n_d  = 1'b0;
        vbat_n_d = 1'b0;
        res_n_d  = 1'b1;
      end
      ST_ON: begin
        vdd_n_d  = 1'b0;
        vbat_n_d = 1'b0;
        res_n_d  = 1'b1;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
      end
      ST_CMD_OFF: begin
        vdd_n_d  = 1'b0;
        vbat_n_d = 1'b0;
        res_n_d  = 1'b1;
        req_d    = 1'b1;
        sel_d    = 1'b1;
      end
      ST_VBAT_OFF: begin
        vdd_n_d = 1'b0;
        res_n_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_OFF;
      timer_q   <= '0;
      abort_q   <= 1'b0;
      vdd_n_o   <= 1'b1;
      vbat_n_o  <= 1'b1;
      res_n_o   <= 1'b0;
      cmd_req_o <= 1'b0;
      cmd_sel_o <= 1'b0;
      ready_o   <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      abort_q   <= abort_d;
      vdd_n_o   <= vdd_n_d;
      vbat_n_o  <= vbat_n_d;
      res_n_o   <= res_n_d;
      cmd_req_o <= req_d;
      cmd_sel_o <= sel_d;
      ready_o   <= ready_d;
      busy_o    <= busy_d;
    end
  end

endmodule

// File: tb/tb_oled_power_sequencer.sv
// Bench for oled_power_sequencer: randomized scenarios against a timeline reference model.
module tb_oled_power_sequencer;

  localparam int TV   = 10;
  localparam int TR   = 3;
  localparam int TBAT = 20;
  localparam int C0   = TV + 3 * TR + 1;  // first CMD_INIT cycle after enable is sampled

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       enable_i = 1'b0;
  logic       cmd_done_i = 1'b0;
  logic       cmd_req_o, cmd_sel_o, vdd_n_o, vbat_n_o, res_n_o, ready_o, busy_o;
  logic [3:0] state_o;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   spi_dly = 5;
  int   spi_age = 0;
  logic req_prev = 1'b0;
  logic done_prev = 1'b0;
  logic spur_done = 1'b0;

  oled_power_sequencer #(
    .T_VDD_CYC (TV),
    .T_RST_CYC (TR),
    .T_VBAT_CYC(TBAT),
    .CNT_W     (23)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .enable_i  (enable_i),
    .cmd_done_i(cmd_done_i),
    .cmd_req_o (cmd_req_o),
    .cmd_sel_o (cmd_sel_o),
    .vdd_n_o   (vdd_n_o),
    .vbat_n_o  (vbat_n_o),
    .res_n_o   (res_n_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o),
    .state_o   (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected {state, vdd_n, vbat_n, res_n, req, sel, ready, busy} for a state number.
  function automatic logic [10:0] exp_out(input int st);
    logic [6:0] o;
    case (st)
      0:       o = 7'b1100000;
      1:       o = 7'b0100001;
      2:       o = 7'b0110001;
      3:       o = 7'b0100001;
      4:       o = 7'b0110001;
      5:       o = 7'b0111001;
      6:       o = 7'b0010001;
      7:       o = 7'b0010010;
      8:       o = 7'b0011101;
      9:       o = 7'b0110001;
      default: o = 7'bxxxxxxx;
    endcase
    return {4'(st), o};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {state_o, vdd_n_o, vbat_n_o, res_n_o, cmd_req_o, cmd_sel_o, ready_o, busy_o};
  endfunction

  // State k cycles after enable is sampled high from OFF, SPI answering after d cycles.
  function automatic int up_state(input int k, input int d);
    if (k <= 0)              return 0;
    if (k <= TV)             return 1;
    if (k <= TV + TR)        return 2;
    if (k <= TV + 2 * TR)    return 3;
    if (k < C0)              return 4;
    if (k <= C0 + d)         return 5;
    if (k <= C0 + d + TBAT)  return 6;
    return 7;
  endfunction

  // State k cycles after a power-down request is sampled from ON/VBAT_ON.
  function automatic int down_state(input int k, input int d);
    if (k <= d + 1)         return 8;
    if (k <= d + 1 + TBAT)  return 9;
    return 0;
  endfunction

  // One clock; the SPI master model pulses done d cycles into each request.
  task automatic tick();
    logic spi_done;
    @(posedge clk_i);
    #1;
    if (cmd_req_o && (!req_prev || done_prev)) spi_age = 0;
    else if (cmd_req_o)                        spi_age++;
    spi_done   = cmd_req_o && (spi_age == spi_dly);
    req_prev   = cmd_req_o;
    done_prev  = spi_done;
    cmd_done_i = spi_done | spur_done;
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    enable_i   = 1'b0;
    spur_done  = 1'b0;
    cmd_done_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] got, want;
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enable_i = 1'(i % 2);
      tick();
      got  = dut_vec();
      want = exp_out(0);
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL reset i=%0d got=%h want=%h", i, got, want);
      end
    end
    enable_i = 1'b0;
    rst_i    = 1'b0;
  endtask

  task automatic test_power_up(input int d, input logic drive_en);
    logic [10:0] got, want;
    spi_dly = d;
    if (drive_en) enable_i = 1'b1;
    for (int k = 1; k <= C0 + d + TBAT + 3; k++) begin
      tick();
      got  = dut_vec();
      want = exp_out(up_state(k, d));
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL power_up d=%0d k=%0d got=%h want=%h", d, k, got, want);
      end
    end
  endtask

  task automatic test_power_down(input int d, input logic reen);
    logic [10:0] got, want;
    int koff, kre, last;
    spi_dly  = d;
    koff     = d + 2 + TBAT;
    kre      = reen ? int'($urandom_range(1, d + 1 + TBAT)) : -1;
    last     = reen ? koff + C0 + d + TBAT + 2 : koff + 3;
    enable_i = 1'b0;
    for (int k = 1; k <= last; k++) begin
      tick();
      got  = dut_vec();
      want = exp_out((k < koff) ? down_state(k, d) : (reen ? up_state(k - koff, d) : 0));
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL power_down d=%0d reen=%0d k=%0d got=%h want=%h", d, reen, k, got, want);
      end
      if (k == kre) enable_i = 1'b1;
    end
  endtask

  task automatic test_abort_early(input int kd);
    logic [10:0] got, want;
    do_reset();
    spi_dly  = 5;
    enable_i = 1'b1;
    for (int k = 1; k <= kd + 4; k++) begin
      tick();
      got  = dut_vec();
      want = exp_out((k <= kd) ? up_state(k, 5) : 0);
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL abort_early kd=%0d k=%0d got=%h want=%h", kd, k, got, want);
      end
      if (k == kd) enable_i = 1'b0;
    end
  endtask

  task automatic test_abort_cmd_init(input int d, input int j);
    logic [10:0] got, want;
    int st;
    do_reset();
    spi_dly  = d;
    enable_i = 1'b1;
    for (int k = 1; k <= C0 + 2 * d + TBAT + 4; k++) begin
      tick();
      if (k <= C0 + d)                 st = up_state(k, d);
      else if (k <= C0 + 2 * d + 1)    st = 8;
      else if (k <= C0 + 2 * d + 1 + TBAT) st = 9;
      else                             st = 0;
      got  = dut_vec();
      want = exp_out(st);
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL abort_cmd_init d=%0d j=%0d k=%0d got=%h want=%h", d, j, k, got, want);
      end
      if (k == C0 + j) enable_i = 1'b0;
    end
  endtask

  task automatic test_abort_vbat_on(input int d, input int j);
    logic [10:0] got, want;
    int kd;
    do_reset();
    spi_dly  = d;
    enable_i = 1'b1;
    kd       = C0 + d + j;
    for (int k = 1; k <= kd + d + TBAT + 4; k++) begin
      tick();
      got  = dut_vec();
      want = exp_out((k <= kd) ? up_state(k, d) : down_state(k - kd, d));
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL abort_vbat_on d=%0d j=%0d k=%0d got=%h want=%h", d, j, k, got, want);
      end
      if (k == kd) enable_i = 1'b0;
    end
  endtask

  task automatic test_rst_mid(input int d, input int j);
    logic [10:0] got, want;
    int kd;
    do_reset();
    spi_dly  = d;
    enable_i = 1'b1;
    kd       = C0 + d + j;
    for (int k = 1; k <= kd; k++) begin
      tick();
      got  = dut_vec();
      want = exp_out(up_state(k, d));
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL rst_mid_pre k=%0d got=%h want=%h", k, got, want);
      end
    end
    rst_i    = 1'b1;
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      rst_i = 1'b0;
      got   = dut_vec();
      want  = exp_out(0);
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL rst_mid i=%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_done_ignored();
    logic [10:0] got, want;
    do_reset();
    spur_done  = 1'b1;
    cmd_done_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      got  = dut_vec();
      want = exp_out(0);
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL done_ignored_off i=%0d got=%h want=%h", i, got, want);
      end
    end
    spur_done = 1'b0;
    tick();
    test_power_up(3, 1'b1);
    spur_done  = 1'b1;
    cmd_done_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      got  = dut_vec();
      want = exp_out(7);
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL done_ignored_on i=%0d got=%h want=%h", i, got, want);
      end
    end
    spur_done = 1'b0;
  endtask

  task automatic test_back_to_back();
    int d;
    logic re;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d = int'($urandom_range(0, 6));
      test_power_up(d, 1'b1);
      d  = int'($urandom_range(0, 6));
      re = 1'($urandom_range(0, 1));
      test_power_down(d, re);
      if (re) test_power_down(int'($urandom_range(0, 6)), 1'b0);
    end
  endtask

  task automatic test_autostart();
    logic [10:0] got, want;
    do_reset();
    test_power_up(5, 1'b0);
    enable_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      got  = dut_vec();
      want = exp_out(7);
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL autostart_on i=%0d got=%h want=%h", i, got, want);
      end
    end
    test_power_down(5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      got  = dut_vec();
      want = exp_out(0);
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL autostart_stays_off i=%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  initial begin
`ifdef OLED_SEQ_AUTOSTART_EN
    test_autostart();
`else
    test_reset();
    test_power_up(5, 1'b1);
    test_power_down(5, 1'b0);
    test_abort_early(4);
    for (int i = 0; i < 4; i++) test_abort_early(int'($urandom_range(1, C0 - 1)));
    test_abort_cmd_init(5, 2);
    for (int i = 0; i < 4; i++) begin
      automatic int d = int'($urandom_range(0, 6));
      test_abort_cmd_init(d, int'($urandom_range(0, d)));
    end
    for (int i = 0; i < 4; i++) test_abort_vbat_on(int'($urandom_range(0, 6)), int'($urandom_range(1, TBAT)));
    test_rst_mid(5, 4);
    test_rst_mid(int'($urandom_range(0, 6)), int'($urandom_range(1, TBAT)));
    test_done_ignored();
    test_back_to_back();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
